// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_bus data memory.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHK_EN.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        err;
        logic [1:0]  size;
        logic [1:0]  lane;
        logic        uns;
        logic [31:0] word;
    } rsp_stg_t;

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] a
    );
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << a;
            SZ_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select with sign or zero extension.
// Used unchanged with or without DMEM_ALIGN_CHK_EN.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word_i[8*lane_i +: 8];
        h = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = {{24{b[7] & ~uns_i}}, b};
            SZ_HALF: data_o = {{16{h[15] & ~uns_i}}, h};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_bus.sv
// MEM-stage data memory: sub-word stores/loads, READ_LAT pipeline, zero sweep.
// Define DMEM_ALIGN_CHK_EN to flag misaligned accesses instead of aligning them.
module dmem_bus
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [DEPTH];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic                  init_wr;

    logic                  accept;
    logic                  misalign;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [31:0]           wdat;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  wr_en;

    rsp_stg_t              stg_d;
    rsp_stg_t              stg_q [READ_LAT];
    rsp_stg_t              last;
    logic [31:0]           al_data;

    logic                  unused_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_wr = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) state_d = ST_RUN;
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);
    assign accept    = req_valid && req_ready;

`ifdef DMEM_ALIGN_CHK_EN
    always_comb begin
        lane     = req_addr[1:0];
        misalign = 1'b0;
        case (req_size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = req_addr[0];
            default: misalign = (req_addr[1:0] != 2'b00);
        endcase
    end
`else
    always_comb begin
        misalign = 1'b0;
        case (req_size)
            SZ_BYTE: lane = req_addr[1:0];
            SZ_HALF: lane = {req_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end
`endif

    // Replicate store data so each enabled lane sees its own copy.
    always_comb begin
        case (req_size)
            SZ_BYTE: wdat = {4{req_wdata[7:0]}};
            SZ_HALF: wdat = {2{req_wdata[15:0]}};
            default: wdat = req_wdata;
        endcase
    end

    assign be          = byte_en(req_size, lane);
    assign idx         = req_addr[DEPTH_LOG2+1:2];
    assign wr_en       = accept && req_we && !misalign && !rst;
    assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2]};

    always_ff @(posedge clk) begin
        if (init_wr && !rst) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    always_comb begin
        stg_d.valid = accept;
        stg_d.we    = req_we;
        stg_d.err   = misalign;
        stg_d.size  = req_size;
        stg_d.lane  = lane;
        stg_d.uns   = req_unsigned;
        stg_d.word  = mem_q[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) stg_q[i] <= '0;
        end else begin
            stg_q[0] <= stg_d;
            for (int i = 1; i < READ_LAT; i++) stg_q[i] <= stg_q[i-1];
        end
    end

    assign last = stg_q[READ_LAT-1];

    dmem_load_align u_align (
        .word_i (last.word),
        .size_i (last.size),
        .lane_i (last.lane),
        .uns_i  (last.uns),
        .data_o (al_data)
    );

    assign resp_valid = last.valid;
    assign resp_rdata = (last.valid && !last.we && !last.err) ? al_data : '0;

`ifdef DMEM_ALIGN_CHK_EN
    assign resp_err = last.valid & last.err;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bus.sv
// Directed bench for dmem_bus: two instances (READ_LAT 1 and 3), DEPTH_LOG2=4.
// Misalignment vectors follow DMEM_ALIGN_CHK_EN.
module tb_dmem_bus;

    localparam int DL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy1, rv1, re1, id1;
    logic [31:0] rd1;
    logic        rdy3, rv3, re3, id3;
    logic [31:0] rd3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_bus #(.DEPTH_LOG2(DL), .READ_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
        .resp_rdata(rd1), .resp_err(re1), .init_done(id1)
    );

    dmem_bus #(.DEPTH_LOG2(DL), .READ_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3),
        .resp_rdata(rd3), .resp_err(re3), .init_done(id3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [31:0] d,
                       input logic e);
        exp_t  x;
        string n;
        n = (k == 0) ? "L1" : "L3";
        if (v) begin
            if (q[k].size() == 0) begin
                chk({n, "_unexp_valid"}, 32'd1, 32'd0);
            end else begin
                x = q[k].pop_front();
                chk({n, "_cycle"}, cyc, x.cyc);
                chk({n, "_rdata"}, d, x.d);
                chk({n, "_err"}, {31'b0, e}, {31'b0, x.e});
            end
        end else if (q[k].size() > 0 && q[k][0].cyc <= cyc) begin
            chk({n, "_missing_valid"}, 32'd0, 32'd1);
            void'(q[k].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, rv1, rd1, re1);
        mon(1, rv3, rd3, re3);
    end

    task automatic init_wait();
        for (int i = 0; i < (1 << DL); i++) begin
            @(negedge clk);
            chk("init_ready_l1", {31'b0, rdy1}, 32'd0);
            chk("init_ready_l3", {31'b0, rdy3}, 32'd0);
            if (i == 0) begin
                chk("init_done_l1", {31'b0, id1}, 32'd0);
                chk("init_rv_l3", {31'b0, rv3}, 32'd0);
            end
        end
        @(negedge clk);
        chk("run_ready_l1", {31'b0, rdy1}, 32'd1);
        chk("run_ready_l3", {31'b0, rdy3}, 32'd1);
        chk("run_done_l1", {31'b0, id1}, 32'd1);
        chk("run_done_l3", {31'b0, id3}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee);
        exp_t x;
        req_valid    = 1'b1;
        req_we       = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        chk("req_ready", {31'b0, rdy1}, 32'd1);
        x.d = er;
        x.e = ee;
        x.cyc = cyc + 1;
        q[0].push_back(x);
        x.cyc = cyc + 3;
        q[1].push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_we    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, rdy1}, 32'd0);
        chk("rst_rv", {31'b0, rv1}, 32'd0);
        chk("rst_rdata", rd3, 32'd0);
        chk("rst_err", {31'b0, re3}, 32'd0);
        chk("rst_done", {31'b0, id3}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_wait();

        issue(0, 2'b10, 0, 32'h3C, 0, 32'h0, 0);
        idle(4);

        issue(1, 2'b10, 0, 32'h08, 32'h11223344, 32'h0, 0);
        issue(0, 2'b00, 0, 32'h09, 0, 32'h00000033, 0);
        issue(0, 2'b00, 1, 32'h0B, 0, 32'h00000011, 0);
        idle(4);

        issue(1, 2'b10, 0, 32'h00, 32'h000080FF, 32'h0, 0);
        issue(0, 2'b01, 0, 32'h00, 0, 32'hFFFF80FF, 0);
        issue(0, 2'b01, 1, 32'h00, 0, 32'h000080FF, 0);
        idle(4);

        issue(1, 2'b10, 0, 32'h04, 32'h12345678, 32'h0, 0);
        issue(1, 2'b00, 0, 32'h06, 32'h555555AA, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h04, 0, 32'h12AA5678, 0);
        issue(0, 2'b00, 0, 32'h06, 0, 32'hFFFFFFAA, 0);
        issue(0, 2'b00, 1, 32'h07, 0, 32'h00000012, 0);
        idle(4);

        issue(1, 2'b01, 0, 32'h0A, 32'h7777BEEF, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h08, 0, 32'hBEEF3344, 0);
        issue(0, 2'b01, 0, 32'h0A, 0, 32'hFFFFBEEF, 0);
        idle(4);

        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0);
        issue(0, 2'b11, 0, 32'h50, 0, 32'hDEADBEEF, 0);
        idle(4);

`ifdef DMEM_ALIGN_CHK_EN
        issue(1, 2'b10, 0, 32'h02, 32'hCAFEF00D, 32'h0, 1);
        issue(0, 2'b01, 0, 32'h01, 0, 32'h0, 1);
        issue(0, 2'b10, 0, 32'h00, 0, 32'h000080FF, 0);
`else
        issue(1, 2'b10, 0, 32'h02, 32'hCAFEF00D, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h00, 0, 32'hCAFEF00D, 0);
        issue(0, 2'b01, 0, 32'h03, 0, 32'hFFFFCAFE, 0);
`endif
        idle(4);

        // Two loads in flight, then reset with a store presented alongside.
        issue(0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0);
        issue(0, 2'b10, 0, 32'h04, 0, 32'h12AA5678, 0);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        req_wdata = 32'h99999999;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            while (q[k].size() > 0 && q[k][$].cyc >= cyc)
                void'(q[k].pop_back());
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        rst       = 1'b0;
        init_wait();

        issue(0, 2'b10, 0, 32'h10, 0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h08, 0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h20, 0, 32'h0, 0);
        idle(6);

        chk("drain_l1", q[0].size(), 32'd0);
        chk("drain_l3", q[1].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus.md
# dmem_bus

Parametrised successor to the pipeline's single-cycle word data memory. It adds byte, halfword and word stores with lane merging, and sign- or zero-extended sub-word loads. Reads are synchronous with a configurable latency and use a valid/ready request interface. After reset, a hardware zero-initialisation sweep clears the array. It sits in the MEM stage between the ALU result/rt forwarding path and the WB mux.

## Interface
Parameters:
- DEPTH_LOG2, 10: word count is 2^DEPTH_LOG2; word index is req_addr[DEPTH_LOG2+1:2].
- READ_LAT, 1: response latency in cycles; legal range 1..3.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: block accepts a request this cycle.
- req_we, in, 1: 1 = store, 0 = load.
- req_size, in, 2: 00 byte, 01 half, 10 word; 11 is reserved and treated as word.
- req_unsigned, in, 1: zero-extend loads (lbu/lhu); ignored for word loads and for stores.
- req_addr, in, 32: byte address; bits above DEPTH_LOG2+1 are ignored (address wraps).
- req_wdata, in, 32: store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- resp_valid, out, 1: response for an accepted request.
- resp_rdata, out, 32: extended load data; 0 for stores and errored requests.
- resp_err, out, 1: misaligned access (see Configuration).
- init_done, out, 1: zero-initialisation sweep complete.

## Operation
- FSM states:
  - INIT: a counter walks word indices 0..2^DEPTH_LOG2-1, writing 0 to one word per cycle. req_ready=0. Goes to RUN after the last index is written.
  - RUN: req_ready=1 and init_done=1. The block is fully pipelined: one request accepted per cycle, no backpressure.
- A request is accepted when req_valid && req_ready.
- Stores:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - wdata is replicated across lanes. Only the selected byte enables write; unselected bytes keep their old value.
  - Commit happens at the accepting edge.
- Loads:
  - Read the word, select the lane, then sign-extend (req_unsigned=0) or zero-extend.
- Every accepted request, load or store, produces exactly one resp_valid pulse, in order.
- Hazards:
  - A load accepted in the cycle after a store to the same word sees the stored data.
  - There is no same-cycle conflict, since only one request is accepted per cycle.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0. The FSM enters INIT with the counter at 0.
- rst deasserted at cycle 0 → INIT occupies cycles 0..2^DEPTH_LOG2-1. req_ready and init_done rise in cycle 2^DEPTH_LOG2.
- Request accepted in cycle n → resp_valid, resp_rdata and resp_err are valid in cycle n+READ_LAT, for exactly one cycle.
- Reset mid-operation:
  - All in-flight responses are dropped; resp_valid=0 from the next cycle.
  - INIT restarts from index 0, and memory contents are cleared again.
  - A store accepted in the same cycle that rst is high is not committed.
- resp_valid is not backpressured; the consumer must take every response.

## Configuration
- DMEM_ALIGN_CHK_EN defined:
  - Half access with addr[0]=1, or word access with addr[1:0]≠00, is misaligned.
  - A misaligned request is accepted but not written, and returns resp_err=1 with resp_rdata=0 at the normal latency.
- DMEM_ALIGN_CHK_EN undefined:
  - Low address bits are forced to alignment (addr[0] cleared for half, addr[1:0] cleared for word).
  - The access proceeds normally; resp_err is tied to 0.

## Structure
- Shared package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state type {ST_INIT, ST_RUN};
  - function computing the 4-bit byte-enable from size and addr[1:0].
- Sub-module dmem_load_align: combinational lane select plus sign/zero extension. Inputs are the 32-bit word, size, addr[1:0] and unsigned; output is 32-bit data. It is instantiated at the final read pipeline stage.
- Response pipeline: READ_LAT stages carrying valid, size, lane, unsigned and err alongside the read word.

## Test plan
- Reset, then idle with DEPTH_LOG2=4 → req_ready=0 for 16 cycles and high in cycle 16; a load of word 15 returns 0x00000000.
- sw 0x11223344 @0x8, then lb @0x9 and lbu @0xB → with READ_LAT=1, responses 0x00000033 and 0x00000011, one cycle after each request.
- sw 0x000080FF @0x0, then lh @0x0 / lhu @0x0 → 0xFFFF80FF / 0x000080FF.
- sb 0xAA @0x6 over a word holding 0x12345678 @0x4 → lw @0x4 returns 0x12AA5678; stores produce one resp_valid pulse each.
- Back-to-back requests (READ_LAT=3): sw 0xDEADBEEF @0x10 in cycle n, lw @0x10 in cycle n+1 → resp_valid in cycles n+3 and n+4, the latter with rdata 0xDEADBEEF.
- With DMEM_ALIGN_CHK_EN: sw @0x2 → resp_err=1 and memory unchanged. rst pulsed while 2 loads are in flight → no resp_valid, INIT restarts, and the earlier sw data reads back as 0.
